// File: rtl/instr_prefetch_mem_if.sv
// -----------------------------------------------------------------------------
// instr_prefetch_mem_if
// Groups the host load port, run control and the instruction stream towards the
// fetch/decode stage.
//
// Handshake (instr_*): a word moves on every rising clock edge where
// instr_valid && instr_ready are both high. While instr_valid is high and
// instr_ready is low, instr_data and instr_pc hold their values. The producer
// never waits for instr_ready before raising instr_valid. A flush is the only
// thing that can drop instr_valid without a transfer.
//
// Modports:
//   master : host/pipeline side (drives wr_*, prog_len, start, flush*,
//            instr_ready; observes everything else)
//   slave  : instr_prefetch_mem itself
//   dbg_state exposes the FSM state (0 = IDLE, 1 = RUN).
// -----------------------------------------------------------------------------
interface instr_prefetch_mem_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 8
);
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [INSTR_W-1:0] wr_data;
  logic               wr_err;
  logic [ADDR_W:0]    prog_len;
  logic               start;
  logic               flush;
  logic [ADDR_W-1:0]  flush_pc;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_data;
  logic [ADDR_W-1:0]  instr_pc;
  logic               busy;
  logic               done;
  logic               dbg_state;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, flush, flush_pc, instr_ready,
    input  wr_err, instr_valid, instr_data, instr_pc, busy, done, dbg_state
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, flush, flush_pc, instr_ready,
    output wr_err, instr_valid, instr_data, instr_pc, busy, done, dbg_state
  );
endinterface

// File: rtl/instr_prefetch_mem.sv
// -----------------------------------------------------------------------------
// instr_prefetch_mem
// On-chip instruction store loaded by the host while IDLE, plus a small
// prefetch FIFO that streams a program of prog_len words, starting at PC 0, to
// the fetch stage. Supports a flush/redirect and a sticky done flag.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset (memory contents are kept)
//   bus  : instr_prefetch_mem_if.slave -- host write port (wr_en/wr_addr/
//          wr_data/wr_err), run control (prog_len/start/flush/flush_pc/busy/
//          done), instruction stream (instr_valid/instr_ready/instr_data/
//          instr_pc) and dbg_state.
// -----------------------------------------------------------------------------
module instr_prefetch_mem #(
  parameter int INSTR_W    = 32,
  parameter int DEPTH      = 256,
  parameter int ADDR_W     = $clog2(DEPTH),
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  instr_prefetch_mem_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W:0]  MAX_LEN   = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t             r_state;
  logic [INSTR_W-1:0] r_mem [DEPTH];
  logic [INSTR_W-1:0] r_rd_data;
  logic [ADDR_W-1:0]  r_rd_pc;
  logic               r_inflight;
  logic [INSTR_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [ADDR_W-1:0]  r_fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic [ADDR_W:0]    r_len;
  logic [ADDR_W:0]    r_fetch_pc;
  logic               r_done;
  logic               r_wr_err;

  logic               w_idle;
  logic               w_run;
  logic               w_start_go;
  logic               w_start_zero;
  logic               w_flush;
  logic               w_flush_end;
  logic               w_valid;
  logic               w_pop;
  logic               w_push;
  logic [CNT_W-1:0]   w_occ;
  logic               w_issue_run;
  logic               w_issue;
  logic [ADDR_W-1:0]  w_rd_addr;
  logic [ADDR_W:0]    w_len_clamped;
  logic               w_finish;

  assign w_idle       = (r_state == S_IDLE);
  assign w_run        = (r_state == S_RUN);
  assign w_start_go   = w_idle & bus.start & (bus.prog_len != '0);
  assign w_start_zero = w_idle & bus.start & (bus.prog_len == '0);
  assign w_flush      = w_run & bus.flush;
  assign w_flush_end  = w_flush & ({1'b0, bus.flush_pc} >= r_len);
  assign w_valid      = (r_count != '0);
  assign w_pop        = w_valid & bus.instr_ready;
  // A word returning in the flush cycle belongs to the old path: drop it.
  assign w_push       = r_inflight & ~w_flush;
  // Counting the in-flight read as occupied guarantees its FIFO slot exists.
  assign w_occ        = r_count + {{(CNT_W-1){1'b0}}, r_inflight};
  assign w_issue_run  = w_run & ~bus.flush & (r_fetch_pc < r_len) & (w_occ < FIFO_FULL);
  // The start cycle itself reads PC 0 so the first word is valid two cycles later.
  assign w_issue      = w_start_go | w_issue_run;
  assign w_rd_addr    = w_start_go ? '0 : r_fetch_pc[ADDR_W-1:0];
  assign w_len_clamped = (bus.prog_len > MAX_LEN) ? MAX_LEN : bus.prog_len;
  // Finish in the cycle the last word leaves, so done appears right after it.
  assign w_finish     = w_run & ~bus.flush & (r_fetch_pc >= r_len) & ~r_inflight &
                        ((r_count == '0) | ((r_count == CNT_W'(1)) & w_pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_fetch_pc <= '0;
      r_inflight <= 1'b0;
      r_rd_pc    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_done     <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_wr_err   <= bus.wr_en & ~w_idle;
      r_inflight <= w_issue;
      if (w_issue) r_rd_pc <= w_rd_addr;
      if (w_idle) begin
        if (w_start_zero) begin
          r_done <= 1'b1;
        end else if (w_start_go) begin
          r_len      <= w_len_clamped;
          r_fetch_pc <= (ADDR_W + 1)'(1);
          r_done     <= 1'b0;
          r_state    <= S_RUN;
        end
      end else begin
        if (w_flush) begin
          // Any transfer in this cycle has already happened; empty the FIFO.
          r_fetch_pc <= {1'b0, bus.flush_pc};
          r_wr_ptr   <= '0;
          r_rd_ptr   <= '0;
          r_count    <= '0;
          if (w_flush_end) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end else begin
          if (w_issue_run) r_fetch_pc <= r_fetch_pc + 1'b1;
          if (w_push)      r_wr_ptr   <= r_wr_ptr + 1'b1;
          if (w_pop)       r_rd_ptr   <= r_rd_ptr + 1'b1;
          r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
          if (w_finish) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
      end
    end
  end

  // Storage arrays carry no reset; the program survives rst.
  always_ff @(posedge clk) begin
    if (bus.wr_en && w_idle) r_mem[bus.wr_addr] <= bus.wr_data;
    if (w_issue) r_rd_data <= r_mem[w_rd_addr];
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_rd_data;
      r_fifo_pc[r_wr_ptr]   <= r_rd_pc;
    end
  end

  // Head is gated with valid so every output reads 0 straight out of reset.
  assign bus.instr_valid = w_valid;
  assign bus.instr_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign bus.instr_pc    = w_valid ? r_fifo_pc[r_rd_ptr] : '0;
  assign bus.busy        = w_run;
  assign bus.done        = r_done;
  assign bus.wr_err      = r_wr_err;
  assign bus.dbg_state   = r_state;
endmodule
